mux_demux_router: RTL and testbench

MUX_DEMUX_ROUTER -- requirements
Module: mux_demux_router

---
 rtl/mux_demux_router.sv | 147 ++++++++++++++
 tb/tb_mux_demux_router.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_demux_router.sv
// N_SRC -> N_DST single-entry router: arbitrate eligible sources, hold one word, present it on its lane.
// Define MUX_DEMUX_RR_ARB_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module mux_demux_router #(
    parameter int unsigned DW    = 4,
    parameter int unsigned N_SRC = 4,
    parameter int unsigned N_DST = 4,
    localparam int unsigned SW   = ($clog2(N_SRC) > 0) ? $clog2(N_SRC) : 1,
    localparam int unsigned TW   = ($clog2(N_DST) > 0) ? $clog2(N_DST) : 1
) (
    input  logic                clk,
    input  logic                reset_p,
    input  logic [N_SRC-1:0]    in_valid,
    input  logic [N_SRC*DW-1:0] in_data,
    input  logic [N_SRC*TW-1:0] in_dest,
    output logic [N_SRC-1:0]    in_ready,
    output logic [N_DST-1:0]    out_valid,
    output logic [N_DST*DW-1:0] out_data,
    input  logic [N_DST-1:0]    out_ready,
    output logic [SW-1:0]       grant_idx,
    output logic                busy
);

    localparam int unsigned OW = N_DST * DW;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [DW-1:0]   data_q, data_d;
    logic [TW-1:0]   dest_q, dest_d;
    logic [N_DST-1:0] out_valid_q, out_valid_d;
    logic [OW-1:0]   out_data_q, out_data_d;
    logic [SW-1:0]   grant_q, grant_d;
    logic            busy_q, busy_d;

    logic [N_SRC-1:0] eligible;
    logic             sink_ready;
    logic             found;
    logic             load;
    logic [SW-1:0]    win;

    // Out-of-range destinations are never eligible.
    always_comb begin
        for (int s = 0; s < N_SRC; s++) begin
            eligible[s] = in_valid[s] && (32'(in_dest[s*TW +: TW]) < N_DST);
        end
    end

    // Only the addressed lane's ready matters.
    always_comb begin
        sink_ready = 1'b0;
        for (int d = 0; d < N_DST; d++) begin
            if (dest_q == TW'(d)) begin
                sink_ready = out_ready[d];
            end
        end
    end

`ifdef MUX_DEMUX_RR_ARB_EN
    // rr_q holds the search start, i.e. (last grant + 1) mod N_SRC.
    logic [SW-1:0] rr_q, rr_d;

    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (!found && eligible[(32'(rr_q) + 32'(i)) % N_SRC]) begin
                found = 1'b1;
                win   = SW'((32'(rr_q) + 32'(i)) % N_SRC);
            end
        end
        rr_d = load ? SW'((32'(win) + 32'd1) % N_SRC) : rr_q;
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end
`else
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int s = 0; s < N_SRC; s++) begin
            if (!found && eligible[s]) begin
                found = 1'b1;
                win   = SW'(s);
            end
        end
    end
`endif

    assign load     = !reset_p && found && ((state_q == IDLE) || sink_ready);
    assign in_ready = load ? (N_SRC'(1) << win) : '0;

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        dest_d      = dest_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        grant_d     = grant_q;
        if (load) begin
            state_d     = HOLD;
            data_d      = in_data[32'(win)*DW +: DW];
            dest_d      = in_dest[32'(win)*TW +: TW];
            out_valid_d = N_DST'(1) << dest_d;
            out_data_d  = OW'(data_d) << (32'(dest_d) * DW);
            grant_d     = win;
        end else if ((state_q == HOLD) && sink_ready) begin
            state_d     = IDLE;
            out_valid_d = '0;
            out_data_d  = '0;
        end
        busy_d = (state_d == HOLD);
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            state_q     <= IDLE;
            data_q      <= '0;
            dest_q      <= '0;
            out_valid_q <= '0;
            out_data_q  <= '0;
            grant_q     <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            dest_q      <= dest_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            grant_q     <= grant_d;
            busy_q      <= busy_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign grant_idx = grant_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mux_demux_router.sv
// Bench for mux_demux_router: directed vector table, out-of-range dest check, and randomized parameter sweeps.
module tb_mux_demux_router;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit rand_go = 1'b0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- default configuration (4/4/4) ----------------
    logic        rst0;
    logic [3:0]  v0, r0, rdy0, ov0;
    logic [15:0] d0, od0;
    logic [7:0]  t0;
    logic [1:0]  g0;
    logic        b0;

    mux_demux_router #(.DW(4), .N_SRC(4), .N_DST(4)) u0 (
        .clk(clk), .reset_p(rst0), .in_valid(v0), .in_data(d0), .in_dest(t0),
        .in_ready(rdy0), .out_valid(ov0), .out_data(od0), .out_ready(r0),
        .grant_idx(g0), .busy(b0)
    );

    // ---------------- N_DST=3, destination 3 is out of range ----------------
    logic        rst1;
    logic [3:0]  v1, rdy1;
    logic [15:0] d1;
    logic [7:0]  t1;
    logic [2:0]  r1, ov1;
    logic [11:0] od1;
    logic [1:0]  g1;
    logic        b1;

    mux_demux_router #(.DW(4), .N_SRC(4), .N_DST(3)) u1 (
        .clk(clk), .reset_p(rst1), .in_valid(v1), .in_data(d1), .in_dest(t1),
        .in_ready(rdy1), .out_valid(ov1), .out_data(od1), .out_ready(r1),
        .grant_idx(g1), .busy(b1)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  v;
        logic [15:0] d;
        logic [7:0]  t;
        logic [3:0]  r;
        logic [3:0]  e_rdy;
        logic [3:0]  e_ov;
        logic [15:0] e_od;
        logic        e_busy;
        logic [1:0]  e_g;
    } vec_t;

    vec_t tab[$];

    task automatic add(input logic rst, input logic [3:0] v, input logic [15:0] d, input logic [7:0] t,
                       input logic [3:0] r, input logic [3:0] er, input logic [3:0] eo,
                       input logic [15:0] ed, input logic eb, input logic [1:0] eg);
        vec_t x;
        x.rst = rst; x.v = v; x.d = d; x.t = t; x.r = r;
        x.e_rdy = er; x.e_ov = eo; x.e_od = ed; x.e_busy = eb; x.e_g = eg;
        tab.push_back(x);
    endtask

    // ---------------- randomized sweeps with a transaction-level model ----------------
    for (genvar c = 0; c < 3; c++) begin : g_rand
        localparam int unsigned RDW = (c == 0) ? 1 : (c == 1) ? 8 : 4;
        localparam int unsigned RNS = (c == 0) ? 2 : 5;
        localparam int unsigned RND = (c == 0) ? 2 : (c == 1) ? 16 : 3;
        localparam int unsigned RSW = $clog2(RNS);
        localparam int unsigned RTW = $clog2(RND);
        localparam int unsigned ROW = RND * RDW;

        logic               rst;
        logic [RNS-1:0]     v, rdy;
        logic [RNS*RDW-1:0] d;
        logic [RNS*RTW-1:0] t;
        logic [RND-1:0]     r, ov;
        logic [ROW-1:0]     od;
        logic [RSW-1:0]     gi;
        logic               bz;
        bit                 done = 1'b0;

        mux_demux_router #(.DW(RDW), .N_SRC(RNS), .N_DST(RND)) u_dut (
            .clk(clk), .reset_p(rst), .in_valid(v), .in_data(d), .in_dest(t),
            .in_ready(rdy), .out_valid(ov), .out_data(od), .out_ready(r),
            .grant_idx(gi), .busy(bz)
        );

        initial begin
            int hv, ht, gm, rp, g, sel;
            bit canload;
            logic [RDW-1:0] hd, wd;
            logic [RNS-1:0] e_rdy;
            logic [RND-1:0] e_ov;
            logic [ROW-1:0] e_od;
            logic [RDW-1:0] wq[$];
            int tq[$];
            rst = 1'b1; v = '0; d = '0; t = '0; r = '0;
            hv = 0; ht = 0; hd = '0; gm = 0; rp = 0; g = 0; sel = 0;
            wait (rand_go);
            @(posedge clk); @(posedge clk); #1;
            rst = 1'b0;
            for (int k = 0; k < 600; k++) begin
                v = RNS'($urandom);
                d = (RNS*RDW)'({$urandom, $urandom});
                t = (RNS*RTW)'($urandom);
                r = RND'($urandom | $urandom);
                #1;
                // choose winner by scanning sources in arbitration order
                canload = 1'b0;
                g = 0;
                for (int i = 0; i < RNS; i++) begin
`ifdef MUX_DEMUX_RR_ARB_EN
                    sel = (rp + i) % RNS;
`else
                    sel = i;
`endif
                    if (!canload && v[sel] && (int'(t[sel*RTW +: RTW]) < RND)) begin
                        canload = 1'b1;
                        g = sel;
                    end
                end
                if (hv != 0 && !r[ht]) canload = 1'b0;
                e_rdy = canload ? (RNS'(1) << g) : '0;
                e_ov  = (hv != 0) ? (RND'(1) << ht) : '0;
                e_od  = (hv != 0) ? (ROW'(hd) << (ht * RDW)) : '0;
                chk($sformatf("rnd%0d_in_ready", c), 256'(rdy), 256'(e_rdy));
                chk($sformatf("rnd%0d_out_valid", c), 256'(ov), 256'(e_ov));
                chk($sformatf("rnd%0d_out_data", c), 256'(od), 256'(e_od));
                chk($sformatf("rnd%0d_grant", c), 256'(gi), 256'(gm));
                chk($sformatf("rnd%0d_busy", c), 256'(bz), 256'(hv != 0));
                // scoreboard: every observed delivery must match the oldest accepted word
                for (int j = 0; j < RND; j++) begin
                    if (ov[j] && r[j]) begin
                        chk($sformatf("rnd%0d_sb_nonempty", c), 256'(wq.size() > 0), 256'(1));
                        if (wq.size() > 0) begin
                            wd = od[j*RDW +: RDW];
                            chk($sformatf("rnd%0d_sb_word", c), 256'({32'(j), 32'(wd)}),
                                256'({32'(tq[0]), 32'(wq[0])}));
                            void'(wq.pop_front());
                            void'(tq.pop_front());
                        end
                    end
                end
                if (canload) begin
                    hv = 1;
                    hd = d[g*RDW +: RDW];
                    ht = int'(t[g*RTW +: RTW]);
                    gm = g;
                    rp = (g + 1) % RNS;
                    wq.push_back(hd);
                    tq.push_back(ht);
                end else if (hv != 0 && r[ht]) begin
                    hv = 0;
                end
                @(posedge clk); #1;
            end
            v = '0;
            chk($sformatf("rnd%0d_sb_residual", c), 256'(wq.size()), 256'(hv));
            done = 1'b1;
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst0 = 1'b1; v0 = '0; d0 = '0; t0 = '0; r0 = '0;
        rst1 = 1'b1; v1 = '0; d1 = '0; t1 = '0; r1 = '0;

        // single grant, hold under backpressure, drain
        add(0, 4'b0100, 16'h0A00, 8'h30, 4'b0000, 4'b0100, 4'b0000, 16'h0000, 0, 2'd0);
        for (int i = 0; i < 5; i++)
            add(0, 4'b0001, 16'h0005, 8'h00, 4'b0111, 4'b0000, 4'b1000, 16'hA000, 1, 2'd2);
        add(0, 4'b0000, 16'h0000, 8'h00, 4'b1000, 4'b0000, 4'b1000, 16'hA000, 1, 2'd2);
        add(0, 4'b0000, 16'h0000, 8'h00, 4'b0000, 4'b0000, 4'b0000, 16'h0000, 0, 2'd2);
        // back-to-back with every source requesting (reset first so arbitration restarts)
        add(1, 4'b1111, 16'h4321, 8'hE4, 4'b1111, 4'b0000, 4'b0000, 16'h0000, 0, 2'd2);
`ifdef MUX_DEMUX_RR_ARB_EN
        add(0, 4'b1111, 16'h4321, 8'hE4, 4'b1111, 4'b0001, 4'b0000, 16'h0000, 0, 2'd0);
        add(0, 4'b1111, 16'h4321, 8'hE4, 4'b1111, 4'b0010, 4'b0001, 16'h0001, 1, 2'd0);
        add(0, 4'b1111, 16'h4321, 8'hE4, 4'b1111, 4'b0100, 4'b0010, 16'h0020, 1, 2'd1);
        add(0, 4'b1111, 16'h4321, 8'hE4, 4'b1111, 4'b1000, 4'b0100, 16'h0300, 1, 2'd2);
        add(0, 4'b1111, 16'h4321, 8'hE4, 4'b1111, 4'b0001, 4'b1000, 16'h4000, 1, 2'd3);
`else
        add(0, 4'b1111, 16'h4321, 8'hE4, 4'b1111, 4'b0001, 4'b0000, 16'h0000, 0, 2'd0);
        for (int i = 0; i < 4; i++)
            add(0, 4'b1111, 16'h4321, 8'hE4, 4'b1111, 4'b0001, 4'b0001, 16'h0001, 1, 2'd0);
`endif
        add(0, 4'b0000, 16'h0000, 8'h00, 4'b1111, 4'b0000, 4'b0001, 16'h0001, 1, 2'd0);
        add(0, 4'b0000, 16'h0000, 8'h00, 4'b1111, 4'b0000, 4'b0000, 16'h0000, 0, 2'd0);
        // reset pulse while holding discards the word
        add(0, 4'b0100, 16'h0B00, 8'h10, 4'b0000, 4'b0100, 4'b0000, 16'h0000, 0, 2'd0);
        add(0, 4'b0000, 16'h0000, 8'h00, 4'b0000, 4'b0000, 4'b0010, 16'h00B0, 1, 2'd2);
        add(1, 4'b1111, 16'h4321, 8'hE4, 4'b1111, 4'b0000, 4'b0010, 16'h00B0, 1, 2'd2);
        for (int i = 0; i < 4; i++)
            add(0, 4'b0000, 16'h0000, 8'h00, 4'b1111, 4'b0000, 4'b0000, 16'h0000, 0, 2'd0);

        @(posedge clk); @(posedge clk); #1;
        foreach (tab[i]) begin
            rst0 = tab[i].rst; v0 = tab[i].v; d0 = tab[i].d; t0 = tab[i].t; r0 = tab[i].r;
            #1;
            chk($sformatf("v%0d_in_ready", i), 256'(rdy0), 256'(tab[i].e_rdy));
            chk($sformatf("v%0d_out_valid", i), 256'(ov0), 256'(tab[i].e_ov));
            chk($sformatf("v%0d_out_data", i), 256'(od0), 256'(tab[i].e_od));
            chk($sformatf("v%0d_busy", i), 256'(b0), 256'(tab[i].e_busy));
            chk($sformatf("v%0d_grant", i), 256'(g0), 256'(tab[i].e_g));
            @(posedge clk); #1;
        end

        // source 1 addresses lane 3 on a 3-lane router: never granted
        v1 = 4'b0010; t1 = 8'h0C; d1 = 16'h00F0; r1 = 3'b111;
        #1;
        chk("oor_in_ready_in_reset", 256'(rdy1), 256'(0));
        rst1 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            chk("oor_in_ready", 256'(rdy1), 256'(0));
            chk("oor_out_valid", 256'(ov1), 256'(0));
            chk("oor_busy", 256'(b1), 256'(0));
        end

        rand_go = 1'b1;
        wait (g_rand[0].done && g_rand[1].done && g_rand[2].done);
        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
